mem_access_unit: RTL and testbench

- MEM-stage load/store controller sitting directly upstream of the word-addressed data memory (1024 x 32, synchronous write, combinational read gated by MemRead).
- Converts RISC-V byte, halfword and word accesses into word-only memory operations:
  - Loads: lane extraction plus sign/zero extension.
  - Sub-word stores: two-cycle read-modify-write with a pipeline stall.
- Flags misaligned and out-of-range accesses and suppresses them.

---
 rtl/mem_pkg.sv | 68 ++++++
 rtl/load_extend.sv | 15 +
 rtl/mem_access_unit.sv | 118 +++++++++++
 tb/tb_mem_access_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: funct3 encodings,
// the RMW state encoding, the default decoded address width, and the
// lane-merge / load-extend helpers.
package mem_pkg;

    localparam int unsigned ADDR_BITS_DEFAULT = 12;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    // Replace the addressed byte (SB) or halfword (SH) of word with store data.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [2:0]  funct3,
        input logic [31:0] data
    );
        logic [31:0] r;
        r = word;
        if (funct3 == F3_H) begin
            if (lane[1]) r[31:16] = data[15:0];
            else         r[15:0]  = data[15:0];
        end else begin
            case (lane)
                2'd0:    r[7:0]   = data[7:0];
                2'd1:    r[15:8]  = data[7:0];
                2'd2:    r[23:16] = data[7:0];
                default: r[31:24] = data[7:0];
            endcase
        end
        return r;
    endfunction

    // Select the addressed lane of a memory word and sign/zero extend it.
    function automatic logic [31:0] load_ext(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [2:0]  funct3
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'h0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane extraction and extension.
// Ports: dm_rd (raw memory word), addr_lo (byte offset), funct3 (access
// size/signedness) -> load_data (extended result).
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] dm_rd,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    assign load_data = load_ext(dm_rd, addr_lo, funct3);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of a word-addressed data memory.
// Loads are single cycle with lane extraction; SW is a single write; SB/SH
// run a read-modify-write over two cycles, stalling the pipeline for one.
// Misaligned, out-of-range and illegal accesses raise fault and are dropped.
// Ports: clk, rst (async active-low); pipeline side mem_valid, mem_read,
// mem_write, funct3, addr, store_data -> load_data, stall, fault; memory
// side dm_we, dm_mem_read, dm_addr, dm_wd, dm_rd.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEFAULT,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              fault,
    output logic              dm_we,
    output logic              dm_mem_read,
    output logic [31:0]       dm_addr,
    output logic [DATA_W-1:0] dm_wd,
    input  logic [DATA_W-1:0] dm_rd
);

    state_t            state, state_nxt;
    logic [29:0]       cap_addr, cap_addr_nxt;
    logic [DATA_W-1:0] cap_word, cap_word_nxt;
    logic [DATA_W-1:0] ext_data;

    logic is_load, is_store, acc, misalign, out_of_range, bad_f3, req_fault;

    load_extend u_load_extend (
        .dm_rd     (dm_rd),
        .addr_lo   (addr[1:0]),
        .funct3    (funct3),
        .load_data (ext_data)
    );

    // Access classification and fault decode for the presented instruction.
    always_comb begin
        is_load      = mem_read & ~mem_write;
        is_store     = mem_write & ~mem_read;
        acc          = mem_valid & (mem_read ^ mem_write);
        misalign     = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0])
                     || ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        out_of_range = (addr >> ADDR_BITS) != 32'h0;
        bad_f3       = (is_store && !(funct3 inside {F3_B, F3_H, F3_W}))
                     || (is_load && (funct3 inside {3'b011, 3'b110, 3'b111}));
        req_fault    = mem_valid && (((mem_read || mem_write) && (misalign || out_of_range))
                                     || (mem_read && mem_write) || bad_f3);
    end

    // State and captured RMW data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cap_addr <= 30'h0;
            cap_word <= '0;
        end else begin
            state    <= state_nxt;
            cap_addr <= cap_addr_nxt;
            cap_word <= cap_word_nxt;
        end
    end

    // Next state and memory/pipeline controls; everything is forced low in reset.
    always_comb begin
        state_nxt    = state;
        cap_addr_nxt = cap_addr;
        cap_word_nxt = cap_word;
        stall        = 1'b0;
        fault        = 1'b0;
        dm_we        = 1'b0;
        dm_mem_read  = 1'b0;
        dm_addr      = 32'h0;
        dm_wd        = '0;
        load_data    = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    fault = req_fault;
                    if (acc && !req_fault) begin
                        dm_addr = {addr[31:2], 2'b00};
                        if (is_load) begin
                            dm_mem_read = 1'b1;
                            load_data   = ext_data;
                        end else if (funct3 == F3_W) begin
                            dm_we = 1'b1;
                            dm_wd = store_data;
                        end else begin
                            // Sub-word store: read the word now, write it merged next cycle.
                            dm_mem_read  = 1'b1;
                            stall        = 1'b1;
                            cap_addr_nxt = addr[31:2];
                            cap_word_nxt = lane_merge(dm_rd, addr[1:0], funct3, store_data);
                            state_nxt    = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    dm_we     = 1'b1;
                    dm_addr   = {cap_addr, 2'b00};
                    dm_wd     = cap_word;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 16-word data memory, an instruction-level
// reference model of the memory contents and expected outputs, directed
// cases with literal expectations, and a randomized instruction stream.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, load_data;
    logic        stall, fault, dm_we, dm_mem_read;
    logic [31:0] dm_addr, dm_wd, dm_rd;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic        bd_en = 1'b0;
    logic [3:0]  bd_idx = 4'h0;
    logic [31:0] bd_val = 32'h0;

    logic [31:0] obs_ld, obs_wd;
    logic        obs_flt, obs_stall, obs_we, obs_rd;

    mem_access_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .load_data   (load_data),
        .stall       (stall),
        .fault       (fault),
        .dm_we       (dm_we),
        .dm_mem_read (dm_mem_read),
        .dm_addr     (dm_addr),
        .dm_wd       (dm_wd),
        .dm_rd       (dm_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: synchronous write, read gated by MemRead; backdoor preload.
    always @(posedge clk) begin
        if (bd_en)      mem[bd_idx] <= bd_val;
        else if (dm_we) mem[dm_addr[5:2]] <= dm_wd;
    end
    assign dm_rd = dm_mem_read ? mem[dm_addr[5:2]] : 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        mem_valid  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
    endtask

    task automatic junk_inputs();
        mem_valid  = 1'($urandom);
        mem_read   = 1'($urandom);
        mem_write  = 1'($urandom);
        funct3     = 3'($urandom);
        addr       = $urandom;
        store_data = $urandom;
    endtask

    task automatic backdoor(input int idx, input logic [31:0] val);
        idle_inputs();
        bd_en  = 1'b1;
        bd_idx = 4'(idx);
        bd_val = val;
        ref_mem[idx] = val;
        @(posedge clk); #1;
        bd_en = 1'b0;
    endtask

    // Expected behaviour of one presented instruction, from the access rules.
    function automatic void model(
        input  logic v, input logic rd, input logic wr,
        input  logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
        output logic flt, output logic e_rd, output logic e_we, output logic e_stall,
        output logic [31:0] e_ld, output logic [31:0] e_merge
    );
        int          sz;
        logic [31:0] w, sh;
        sz = (f3 == 3'b001 || f3 == 3'b101) ? 2 : (f3 == 3'b010) ? 4 : 1;
        w  = ref_mem[a[5:2]];
        flt = v && (((rd || wr) && ((a % 32'(sz)) != 0 || a >= 32'd4096))
                    || (rd && wr)
                    || (wr && !rd && f3 > 3'd2)
                    || (rd && !wr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})));
        e_rd = 1'b0; e_we = 1'b0; e_stall = 1'b0; e_ld = 32'h0; e_merge = w;
        if (v && !flt && rd && !wr) begin
            e_rd = 1'b1;
            sh   = w >> (8 * a[1:0]);
            if (sz == 1) begin
                e_ld = sh & 32'hFF;
                if (f3 == 3'd0 && e_ld[7]) e_ld = e_ld | 32'hFFFF_FF00;
            end else if (sz == 2) begin
                e_ld = sh & 32'hFFFF;
                if (f3 == 3'd1 && e_ld[15]) e_ld = e_ld | 32'hFFFF_0000;
            end else begin
                e_ld = w;
            end
        end
        if (v && !flt && wr && !rd) begin
            if (f3 == 3'd2) e_we = 1'b1;
            else begin
                e_rd    = 1'b1;
                e_stall = 1'b1;
                for (int i = 0; i < sz; i++)
                    e_merge[8 * (int'(a[1:0]) + i) +: 8] = sd[8 * i +: 8];
            end
        end
    endfunction

    // Present one instruction (holding it through any stall) and check every cycle.
    task automatic do_op(input logic v, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        logic        flt, e_rd, e_we, e_stall;
        logic [31:0] e_ld, e_merge, ea;
        model(v, rd, wr, f3, a, sd, flt, e_rd, e_we, e_stall, e_ld, e_merge);
        ea = {a[31:2], 2'b00};
        mem_valid = v; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        @(negedge clk);
        chk("stall", 32'(stall), 32'(e_stall));
        chk("fault", 32'(fault), 32'(flt));
        chk("dm_we", 32'(dm_we), 32'(e_we));
        chk("dm_mem_read", 32'(dm_mem_read), 32'(e_rd));
        chk("load_data", load_data, e_ld);
        if (e_rd || e_we) chk("dm_addr", dm_addr, ea);
        if (e_we) chk("dm_wd", dm_wd, sd);
        obs_ld = load_data; obs_wd = dm_wd; obs_flt = fault;
        obs_stall = stall; obs_we = dm_we; obs_rd = dm_mem_read;
        @(posedge clk); #1;
        if (e_stall) begin
            junk_inputs();
            @(negedge clk);
            chk("rmw_we", 32'(dm_we), 32'd1);
            chk("rmw_addr", dm_addr, ea);
            chk("rmw_wd", dm_wd, e_merge);
            chk("rmw_stall", 32'(stall), 32'd0);
            chk("rmw_fault", 32'(fault), 32'd0);
            chk("rmw_rd", 32'(dm_mem_read), 32'd0);
            chk("rmw_ld", load_data, 32'h0);
            obs_wd = dm_wd;
            @(posedge clk); #1;
            ref_mem[a[5:2]] = e_merge;
        end else if (e_we) begin
            ref_mem[a[5:2]] = sd;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_stall"}, 32'(stall), 32'd0);
        chk({nm, "_fault"}, 32'(fault), 32'd0);
        chk({nm, "_we"}, 32'(dm_we), 32'd0);
        chk({nm, "_rd"}, 32'(dm_mem_read), 32'd0);
        chk({nm, "_addr"}, dm_addr, 32'h0);
        chk({nm, "_wd"}, dm_wd, 32'h0);
        chk({nm, "_ld"}, load_data, 32'h0);
    endtask

    initial begin
        int c0, nbad;
        logic v, rd, wr;
        logic [2:0] f3;
        logic [31:0] a;

        rst = 1'b0;
        idle_inputs();
        // Reset with an access presented: all outputs low.
        mem_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h10; store_data = 32'hDEADBEEF;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) backdoor(i, $urandom);

        // SW after reset: one write cycle, no stall.
        do_op(1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_we", 32'(obs_we), 32'd1);
        chk("sw_stall", 32'(obs_stall), 32'd0);
        idle_inputs();
        @(negedge clk);
        chk("sw_we_after", 32'(dm_we), 32'd0);
        @(posedge clk); #1;
        do_op(1, 1, 0, 3'b010, 32'h10, 32'h0);
        chk("sw_readback", obs_ld, 32'hDEADBEEF);

        // Loads from 0x8081F2F3.
        backdoor(4, 32'h8081F2F3);
        do_op(1, 1, 0, 3'b000, 32'h13, 32'h0); chk("lb_13", obs_ld, 32'hFFFFFF80);
        do_op(1, 1, 0, 3'b100, 32'h13, 32'h0); chk("lbu_13", obs_ld, 32'h00000080);
        do_op(1, 1, 0, 3'b001, 32'h10, 32'h0); chk("lh_10", obs_ld, 32'hFFFFF2F3);
        do_op(1, 1, 0, 3'b101, 32'h12, 32'h0); chk("lhu_12", obs_ld, 32'h00008081);
        do_op(1, 1, 0, 3'b010, 32'h10, 32'h0); chk("lw_10", obs_ld, 32'h8081F2F3);

        // Sub-word stores via read-modify-write.
        backdoor(4, 32'h11223344);
        do_op(1, 0, 1, 3'b000, 32'h11, 32'h000000AA);
        chk("sb_stall1", 32'(obs_stall), 32'd1);
        chk("sb_wd", obs_wd, 32'h1122AA44);
        do_op(1, 0, 1, 3'b001, 32'h12, 32'h0000BEEF);
        chk("sh_wd", obs_wd, 32'hBEEFAA44);

        // Faulting accesses.
        do_op(1, 1, 0, 3'b010, 32'h6, 32'h0);    chk("flt_lw6", 32'(obs_flt), 32'd1);
        do_op(1, 1, 0, 3'b001, 32'h3, 32'h0);    chk("flt_lh3", 32'(obs_flt), 32'd1);
        do_op(1, 0, 1, 3'b010, 32'h1000, 32'h5); chk("flt_sw1000", 32'(obs_flt), 32'd1);
        chk("flt_sw1000_we", 32'(obs_we), 32'd0);
        do_op(1, 0, 1, 3'b011, 32'h10, 32'h5);   chk("flt_st011", 32'(obs_flt), 32'd1);
        chk("flt_st011_rd", 32'(obs_rd), 32'd0);
        do_op(1, 1, 1, 3'b010, 32'h10, 32'h5);   chk("flt_both", 32'(obs_flt), 32'd1);

        // Back-to-back SB, SB, LW to one word: 5 cycles.
        backdoor(8, 32'h0);
        c0 = cyc;
        do_op(1, 0, 1, 3'b000, 32'h20, 32'h11);
        do_op(1, 0, 1, 3'b000, 32'h21, 32'h22);
        do_op(1, 1, 0, 3'b010, 32'h20, 32'h0);
        chk("b2b_ld", obs_ld, 32'h00002211);
        chk("b2b_cycles", 32'(cyc - c0), 32'd5);

        // Reset asserted mid-run while a load is presented.
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h10;
        #2 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset during the RMW write cycle: write dropped, word unchanged.
        backdoor(9, 32'hCAFEF00D);
        mem_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b000;
        addr = 32'h24; store_data = 32'h77;
        @(negedge clk);
        chk("rmwrst_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("rmwrst");
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("rmwrst_idle_we", 32'(dm_we), 32'd0);
        chk("rmwrst_idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        do_op(1, 1, 0, 3'b010, 32'h24, 32'h0);
        chk("rmwrst_word", obs_ld, 32'hCAFEF00D);

        // Randomized instruction stream.
        for (int n = 0; n < 1500; n++) begin
            int k;
            v = ($urandom_range(0, 99) >= 5);
            k = $urandom_range(0, 19);
            rd = (k == 0) || (k < 10);
            wr = (k == 0) || (k >= 10);
            if ($urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, 4);
                f3 = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : (k == 2) ? 3'd2 : (k == 3) ? 3'd4 : 3'd5;
            end else begin
                f3 = 3'($urandom);
            end
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 63));
            do_op(v, rd, wr, f3, a, $urandom);
        end

        idle_inputs();
        @(posedge clk); #1;
        nbad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) nbad++;
        chk("mem_final", 32'(nbad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
